// File: rtl/pixel_stream_pkg.sv
// Shared types for the pixel stream capture block: pixel and pair layouts and
// the capture FSM state encoding.
package pixel_stream_pkg;

  localparam int unsigned PIX_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // p0 is the even pixel of the pair and occupies the upper bits.
  typedef struct packed {
    rgb_t p0;
    rgb_t p1;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; push and pop in the same cycle are
// legal even when full, because the popped slot is the one being overwritten.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[PTR_W-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/pixel_stream_capture.sv
// Captures one frame of a two-pixels-per-clock video stream and serialises it
// into single-pixel writes on a valid/ready port with linear pixel addresses.
module pixel_stream_capture
  import pixel_stream_pkg::*;
#(
  parameter int unsigned WIDTH      = 768,
  parameter int unsigned HEIGHT     = 512,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [7:0]        DATA_R0,
  input  logic [7:0]        DATA_G0,
  input  logic [7:0]        DATA_B0,
  input  logic [7:0]        DATA_R1,
  input  logic [7:0]        DATA_G1,
  input  logic [7:0]        DATA_B1,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              overflow
);

  localparam int unsigned         IDX_W     = ADDR_W - 1;
  localparam int unsigned         PAIRS     = WIDTH * HEIGHT / 2;
  localparam logic [IDX_W-1:0]    LAST_PAIR = IDX_W'(PAIRS - 1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    pair_t            pair;
  } entry_t;

  cap_state_t       state, state_nxt;
  logic [IDX_W-1:0] pair_cnt;
  entry_t           push_entry, pop_entry;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;

  // Serializer: phase=1 means the odd pixel of the held pair is on the port.
  logic             phase;
  rgb_t             held_p1;
  logic [IDX_W-1:0] held_idx;

  logic start_frame, pair_in, accept, drop;

  assign start_frame = VSYNC && (state == IDLE || state == DONE);
  assign pair_in     = HSYNC && (state == CAPTURE);
  assign accept      = wr_valid && wr_ready;
  assign fifo_pop    = !fifo_empty && (!wr_valid || (accept && phase));
  assign fifo_push   = pair_in && (!fifo_full || fifo_pop);
  assign drop        = pair_in && fifo_full && !fifo_pop;

  assign push_entry  = {pair_cnt, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};
  assign frame_done  = (state == DONE);

  sync_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: next-state is defaulted to the current state before the case so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (VSYNC) state_nxt = CAPTURE;
      CAPTURE: if (HSYNC && pair_cnt == LAST_PAIR) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !wr_valid) state_nxt = DONE;
      DONE:    if (VSYNC) state_nxt = CAPTURE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= IDLE;
      pair_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_frame) begin
        pair_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        // Dropped pairs still advance the index so later addresses stay aligned.
        if (pair_in) pair_cnt <= pair_cnt + IDX_W'(1);
        if (drop)    overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      phase    <= 1'b0;
      held_p1  <= '0;
      held_idx <= '0;
    end else if (fifo_pop) begin
      wr_valid <= 1'b1;
      wr_addr  <= {pop_entry.idx, 1'b0};
      wr_data  <= pop_entry.pair.p0;
      held_p1  <= pop_entry.pair.p1;
      held_idx <= pop_entry.idx;
      phase    <= 1'b0;
    end else if (accept && !phase) begin
      wr_addr  <= {held_idx, 1'b1};
      wr_data  <= held_p1;
      phase    <= 1'b1;
    end else if (accept) begin
      wr_valid <= 1'b0;
    end
  end

endmodule
